// File: rtl/axis_dmux_ctrl_pkg.sv
// Shared types and constants for the axis_dmux_ctrl frame scheduler.
// Optional statistics are built when AXIS_DMUX_CTRL_STATS_EN is defined.
package axis_dmux_ctrl_pkg;

    typedef enum logic [1:0] {
        DECIDE = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_RR    = 2'd1;
    localparam logic [1:0] MODE_TDEST = 2'd2;

    // Round-robin target: the pointer port if it is enabled, otherwise the other one.
    function automatic logic rr_target(input logic ptr, input logic [1:0] port_en);
        return port_en[ptr] ? ptr : ~ptr;
    endfunction

endpackage

// File: rtl/axis_dmux_ctrl_stats.sv
// Saturating per-port frame and drop counters, updated on each frame's tlast beat.
// Instantiated by axis_dmux_ctrl only when AXIS_DMUX_CTRL_STATS_EN is defined.
module axis_dmux_ctrl_stats
    import axis_dmux_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_done,
    input  logic                 frame_drop,
    input  logic                 frame_sel,
    output logic [CNT_WIDTH-1:0] frame_cnt_0,
    output logic [CNT_WIDTH-1:0] frame_cnt_1,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_0 <= '0;
            frame_cnt_1 <= '0;
            drop_cnt    <= '0;
        end else if (frame_done) begin
            if (frame_drop) begin
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end else if (frame_sel) begin
                if (frame_cnt_1 != '1) frame_cnt_1 <= frame_cnt_1 + CNT_WIDTH'(1);
            end else begin
                if (frame_cnt_0 != '1) frame_cnt_0 <= frame_cnt_0 + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/axis_dmux_ctrl.sv
// Frame-level scheduler for the 2-port AXI4-Stream demux (enable/drop/sel).
// Define AXIS_DMUX_CTRL_STATS_EN to build the per-port frame/drop counters.
//
//   state  | meaning
//   DECIDE | sample config, pick target port and drop; tdest mode waits for tvalid
//   ARMED  | demux enabled, waiting for the first beat of the frame
//   ACTIVE | multi-beat frame in flight until its tlast beat
module axis_dmux_ctrl
    import axis_dmux_ctrl_pkg::*;
#(
    parameter int DEST_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_fixed_sel,
    input  logic [1:0]            cfg_port_en,
    output logic                  demux_enable,
    output logic                  demux_drop,
    output logic                  demux_sel,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_cnt_0,
    output logic [CNT_WIDTH-1:0]  frame_cnt_1,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    state_t     state;
    logic       rr_ptr;
    logic [1:0] shadow_mode;
    logic       beat;
    logic       frame_done;
    logic       dec_go;
    logic       dec_sel;
    logic       dec_drop;

    assign beat       = s_axis_tvalid && s_axis_tready;
    assign frame_done = beat && s_axis_tlast && (state != DECIDE);

    // Config is sampled on the cycle the decision is taken, so the first frame
    // after reset already follows cfg_* rather than the all-zero reset shadow.
    always_comb begin
        dec_go   = 1'b1;
        dec_sel  = cfg_fixed_sel;
        dec_drop = 1'b0;
        case (cfg_mode)
            MODE_RR: dec_sel = rr_target(rr_ptr, cfg_port_en);
            MODE_TDEST: begin
                dec_go   = s_axis_tvalid;
                dec_sel  = s_axis_tdest[0];
                dec_drop = (s_axis_tdest > DEST_WIDTH'(1));
            end
            default: dec_sel = cfg_fixed_sel;
        endcase
        if (!cfg_port_en[dec_sel]) dec_drop = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DECIDE;
            demux_enable <= 1'b0;
            demux_drop   <= 1'b0;
            demux_sel    <= 1'b0;
            busy         <= 1'b0;
            rr_ptr       <= 1'b0;
            shadow_mode  <= MODE_FIXED;
        end else begin
            case (state)
                DECIDE: begin
                    if (dec_go) begin
                        demux_sel    <= dec_sel;
                        demux_drop   <= dec_drop;
                        demux_enable <= 1'b1;
                        shadow_mode  <= cfg_mode;
                        state        <= ARMED;
                    end
                end
                ARMED: begin
                    if (beat) begin
                        demux_enable <= 1'b0;
                        if (s_axis_tlast) begin
                            state <= DECIDE;
                        end else begin
                            busy  <= 1'b1;
                            state <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (beat && s_axis_tlast) begin
                        busy  <= 1'b0;
                        state <= DECIDE;
                    end
                end
                default: state <= DECIDE;
            endcase
            if (frame_done && shadow_mode == MODE_RR && !demux_drop) rr_ptr <= ~demux_sel;
        end
    end

`ifdef AXIS_DMUX_CTRL_STATS_EN
    axis_dmux_ctrl_stats #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stats (
        .clk         (clk),
        .rst         (rst),
        .frame_done  (frame_done),
        .frame_drop  (demux_drop),
        .frame_sel   (demux_sel),
        .frame_cnt_0 (frame_cnt_0),
        .frame_cnt_1 (frame_cnt_1),
        .drop_cnt    (drop_cnt)
    );
`else
    assign frame_cnt_0 = '0;
    assign frame_cnt_1 = '0;
    assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_axis_dmux_ctrl.sv
// Self-checking bench for axis_dmux_ctrl: directed frame scenarios plus randomized
// traffic against a frame-level reference model. Counters checked when AXIS_DMUX_CTRL_STATS_EN is defined.
module tb_axis_dmux_ctrl;

    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdest = '0;
    logic [1:0]    cfg_mode = 2'd0;
    logic          cfg_fixed_sel = 1'b0;
    logic [1:0]    cfg_port_en = 2'b11;
    logic          demux_enable, demux_drop, demux_sel, busy;
    logic [CW-1:0] frame_cnt_0, frame_cnt_1, drop_cnt;
    logic          rdy = 1'b0;

    // Demux behaviour: it only accepts beats while enabled or mid-frame.
    assign s_axis_tready = (demux_enable || busy) && rdy;

    axis_dmux_ctrl #(.DEST_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdest  (s_axis_tdest),
        .cfg_mode      (cfg_mode),
        .cfg_fixed_sel (cfg_fixed_sel),
        .cfg_port_en   (cfg_port_en),
        .demux_enable  (demux_enable),
        .demux_drop    (demux_drop),
        .demux_sel     (demux_sel),
        .busy          (busy),
        .frame_cnt_0   (frame_cnt_0),
        .frame_cnt_1   (frame_cnt_1),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input int v);
`ifdef AXIS_DMUX_CTRL_STATS_EN
        return 64'(v);
`else
        return 64'(v - v);
`endif
    endfunction

    // Reference model: frame-level view (waiting for a decision, armed, mid-frame).
    int   m_phase = 0;
    bit   m_sel, m_drop, m_en, m_busy, m_rr;
    logic [1:0] m_mode;
    int   m_fc0, m_fc1, m_dc;
    int   cyc = 0;
    logic q_sel[$];
    logic q_drop[$];
    int   q_t[$];

    task automatic model_complete();
        if (m_mode == 2'd1 && !m_drop) m_rr = !m_sel;
        if (m_drop)     m_dc  = (m_dc  < CMAX) ? m_dc  + 1 : CMAX;
        else if (m_sel) m_fc1 = (m_fc1 < CMAX) ? m_fc1 + 1 : CMAX;
        else            m_fc0 = (m_fc0 < CMAX) ? m_fc0 + 1 : CMAX;
    endtask

    always @(posedge clk) begin
        bit b, go, t, d;
        b = s_axis_tvalid && s_axis_tready;
        cyc++;
        if (started && b) check("beat_window", 64'(demux_enable || busy), 64'd1);
        if (rst) begin
            m_phase = 0; m_sel = 0; m_drop = 0; m_en = 0; m_busy = 0; m_rr = 0;
            m_mode = 2'd0; m_fc0 = 0; m_fc1 = 0; m_dc = 0;
        end else begin
            case (m_phase)
                0: begin
                    go = 1; d = 0;
                    if (cfg_mode == 2'd1) t = cfg_port_en[m_rr] ? m_rr : !m_rr;
                    else if (cfg_mode == 2'd2) begin
                        go = s_axis_tvalid;
                        t  = s_axis_tdest[0];
                        d  = (s_axis_tdest >= 2);
                    end else t = cfg_fixed_sel;
                    if (!cfg_port_en[t]) d = 1;
                    if (go) begin
                        m_sel = t; m_drop = d; m_en = 1; m_mode = cfg_mode; m_phase = 1;
                    end
                end
                1: if (b) begin
                    q_sel.push_back(demux_sel);
                    q_drop.push_back(demux_drop);
                    q_t.push_back(cyc);
                    m_en = 0;
                    if (s_axis_tlast) begin model_complete(); m_phase = 0; end
                    else begin m_busy = 1; m_phase = 2; end
                end
                default: if (b && s_axis_tlast) begin
                    model_complete(); m_busy = 0; m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("enable", 64'(demux_enable), 64'(m_en));
            check("busy",   64'(busy),         64'(m_busy));
            check("sel",    64'(demux_sel),    64'(m_sel));
            check("drop",   64'(demux_drop),   64'(m_drop));
            check("frame_cnt_0", 64'(frame_cnt_0), exp_cnt(m_fc0));
            check("frame_cnt_1", 64'(frame_cnt_1), exp_cnt(m_fc1));
            check("drop_cnt",    64'(drop_cnt),    exp_cnt(m_dc));
        end
    end

    task automatic do_reset();
        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_enable", 64'(demux_enable), 64'd0);
        check("rst_busy",   64'(busy),         64'd0);
        check("rst_sel",    64'(demux_sel),    64'd0);
        check("rst_drop",   64'(demux_drop),   64'd0);
        check("rst_cnt",    64'(frame_cnt_0) + 64'(frame_cnt_1) + 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        started = 1'b1;
        q_sel.delete(); q_drop.delete(); q_t.delete();
    endtask

    // Called and returns at a negedge. chg_at < 0 means no mid-frame mode change.
    task automatic drive_frame(input int len, input logic [DW-1:0] dest, input int chg_at,
                               input logic [1:0] chg_mode, input bit rand_rdy, input int gap);
        bit b;
        int n;
        for (int i = 0; i < len; i++) begin
            if (i == chg_at) cfg_mode = chg_mode;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == len - 1);
            s_axis_tdest  = dest;
            n = 0;
            forever begin
                rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
                @(posedge clk);
                b = s_axis_tvalid && s_axis_tready;
                @(negedge clk);
                if (b) break;
                n++;
                if (n > 100) begin
                    checks++; errors++;
                    $display("FAIL beat_timeout: got no beat expected beat within 100 cycles");
                    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
                    return;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_frames(input string nm, input int n, input logic [7:0] es, input logic [7:0] ed);
        check({nm, "_count"}, 64'(q_sel.size()), 64'(n));
        for (int i = 0; i < n && i < q_sel.size(); i++) begin
            check({nm, "_sel"},  64'(q_sel[i]),  64'(es[i]));
            check({nm, "_drop"}, 64'(q_drop[i]), 64'(ed[i]));
        end
    endtask

    initial begin
        int n;
        @(negedge clk);

        // Fixed mode to port 1, three 4-beat frames.
        cfg_mode = 2'd0; cfg_fixed_sel = 1'b1; cfg_port_en = 2'b11;
        do_reset();
        repeat (3) drive_frame(4, 8'd0, -1, 2'd0, 1'b0, 0);
        repeat (2) @(negedge clk);
        check_frames("fixed", 3, 8'b111, 8'b000);
        check("fixed_model_fc1", 64'(m_fc1), 64'd3);
        check("fixed_dut_fc1", 64'(frame_cnt_1), exp_cnt(3));

        // Round-robin, both ports, four single-beat frames back to back.
        cfg_mode = 2'd1; cfg_port_en = 2'b11;
        do_reset();
        repeat (4) drive_frame(1, 8'd0, -1, 2'd0, 1'b0, 0);
        repeat (2) @(negedge clk);
        check_frames("rr", 4, 8'b1010, 8'b0000);
        for (int i = 0; i + 1 < q_t.size(); i++) check("rr_gap", 64'(q_t[i+1] - q_t[i]), 64'd2);
        check("rr_model_fc0", 64'(m_fc0), 64'd2);
        check("rr_dut_fc0", 64'(frame_cnt_0), exp_cnt(2));
        check("rr_dut_fc1", 64'(frame_cnt_1), exp_cnt(2));

        // Round-robin with only port 0 enabled.
        cfg_mode = 2'd1; cfg_port_en = 2'b01;
        do_reset();
        repeat (3) drive_frame(2, 8'd0, -1, 2'd0, 1'b0, 1);
        repeat (2) @(negedge clk);
        check_frames("rr_p0", 3, 8'b000, 8'b000);
        check("rr_p0_dut_fc0", 64'(frame_cnt_0), exp_cnt(3));

        // tdest mode: 0, 1, 5 with idle gaps in between.
        cfg_mode = 2'd2; cfg_port_en = 2'b11;
        do_reset();
        drive_frame(2, 8'd0, -1, 2'd0, 1'b0, 4);
        check("tdest_wait_enable", 64'(demux_enable), 64'd0);
        drive_frame(1, 8'd1, -1, 2'd0, 1'b0, 4);
        check("tdest_wait_enable2", 64'(demux_enable), 64'd0);
        drive_frame(3, 8'd5, -1, 2'd0, 1'b0, 2);
        check_frames("tdest", 3, 8'b110, 8'b100);
        check("tdest_model_dc", 64'(m_dc), 64'd1);
        check("tdest_dut_dc", 64'(drop_cnt), exp_cnt(1));

        // Fixed -> round-robin change mid-frame takes effect from the next frame.
        cfg_mode = 2'd0; cfg_fixed_sel = 1'b1; cfg_port_en = 2'b11;
        do_reset();
        drive_frame(6, 8'd0, 2, 2'd1, 1'b0, 0);
        drive_frame(1, 8'd0, -1, 2'd0, 1'b0, 0);
        drive_frame(1, 8'd0, -1, 2'd0, 1'b0, 1);
        check_frames("cfg_chg", 3, 8'b101, 8'b000);

        // Reset in the middle of a multi-beat frame.
        cfg_mode = 2'd0; cfg_fixed_sel = 1'b1; cfg_port_en = 2'b11;
        do_reset();
        drive_frame(2, 8'd0, -1, 2'd0, 1'b0, 0);
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; rdy = 1'b1;
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        check("midrst_reached_active", 64'(busy), 64'd1);
        rst = 1'b1; s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("midrst_enable", 64'(demux_enable), 64'd0);
        check("midrst_busy",   64'(busy),         64'd0);
        check("midrst_sel",    64'(demux_sel),    64'd0);
        check("midrst_cnt",    64'(frame_cnt_1),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Counter saturation.
        cfg_mode = 2'd0; cfg_fixed_sel = 1'b0; cfg_port_en = 2'b11;
        do_reset();
        repeat (CMAX + 3) drive_frame(1, 8'd0, -1, 2'd0, 1'b0, 0);
        repeat (2) @(negedge clk);
        check("sat_model_fc0", 64'(m_fc0), 64'(CMAX));
        check("sat_dut_fc0", 64'(frame_cnt_0), exp_cnt(CMAX));

        // Randomized traffic and configuration.
        do_reset();
        for (int f = 0; f < 80; f++) begin
            int len, chg;
            logic [DW-1:0] dest;
            if ($urandom_range(0, 3) == 0) begin
                cfg_mode      = 2'($urandom_range(0, 3));
                cfg_fixed_sel = 1'($urandom_range(0, 1));
                cfg_port_en   = 2'($urandom_range(0, 3));
            end
            len  = $urandom_range(1, 5);
            dest = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(2, 255)) : DW'($urandom_range(0, 1));
            chg  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            drive_frame(len, dest, chg, 2'($urandom_range(0, 3)), 1'b1, $urandom_range(0, 2));
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
